leer_cache: RTL

Read-side controller for the 4-set, 4-way cache. Accepts CPU read requests, looks up tag/valid/data storage held inside this block, and returns hit data in two cycles. On a miss it fetches from memory over a req/ack handshake, then refills the way selected by the round-robin replacement block (`modificar_cache`) through its `i_modify`/`i_block`/`i_index` inputs and one-hot `en_wr` output.

---
 rtl/leer_cache.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/leer_cache.sv
// leer_cache: read-side controller for a 4-set, 4-way cache.
// Looks up requests in local tag/valid/data storage, fetches misses from
// memory over a req/ack handshake and refills the way chosen by the
// external round-robin replacement block.
module leer_cache #(
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_req,
    input  logic [TAG_W+1:0]    i_addr,
    output logic                o_busy,
    output logic                o_rd_valid,
    output logic                o_hit,
    output logic [DATA_W-1:0]   o_rd_data,
    output logic                o_mem_req,
    output logic [TAG_W+1:0]    o_mem_addr,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_data,
    output logic                o_modify,
    output logic                o_block,
    output logic [1:0]          o_index,
    input  logic [3:0]          i_en_wr
);

    localparam int unsigned ADDR_W = TAG_W + 2;
    localparam int unsigned NSETS  = 4;
    localparam int unsigned NWAYS  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS,
        S_REFILL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic                hit_q, hit_d;
    logic                mem_req_q, mem_req_d;
    logic                modify_q, modify_d;
    logic                block_q, block_d;

    logic [NWAYS-1:0]    valid_q [NSETS];
    logic [TAG_W-1:0]    tag_q   [NSETS][NWAYS];
    logic [DATA_W-1:0]   data_q  [NSETS][NWAYS];

    logic [1:0]          set_c;
    logic [TAG_W-1:0]    tag_c;
    logic                wr_c;
    logic                hit_c;
    logic [DATA_W-1:0]   hit_data_c;

    assign set_c = addr_q[1:0];
    assign tag_c = addr_q[ADDR_W-1:2];
    assign wr_c  = (state_q == S_REFILL);

    // Tag compare across the latched set; lowest-numbered matching way wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        for (int w = 0; w < int'(NWAYS); w++) begin
            if (!hit_c && valid_q[set_c][w] && (tag_q[set_c][w] == tag_c)) begin
                hit_c      = 1'b1;
                hit_data_c = data_q[set_c][w];
            end
        end
    end

    // Valid bits: cleared by reset, set for every enabled way on refill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < int'(NSETS); s++) begin
                valid_q[s] <= '0;
            end
        end else if (wr_c) begin
            valid_q[set_c] <= valid_q[set_c] | i_en_wr;
        end
    end

    // Tag and data arrays are not reset; written only for enabled ways on refill.
    always_ff @(posedge i_clk) begin
        if (wr_c) begin
            for (int w = 0; w < int'(NWAYS); w++) begin
                if (i_en_wr[w]) begin
                    tag_q[set_c][w]  <= tag_c;
                    data_q[set_c][w] <= fill_q;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            fill_q     <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            modify_q   <= 1'b0;
            block_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fill_q     <= fill_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
            hit_q      <= hit_d;
            mem_req_q  <= mem_req_d;
            modify_q   <= modify_d;
            block_q    <= block_d;
        end
    end

    // Next-state and next-output logic; state-decoded outputs are computed
    // from the next state so they are registered yet aligned with the state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fill_d     = fill_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        hit_d      = hit_q;
        mem_req_d  = mem_req_q;

        case (state_q)
            S_IDLE: begin
                if (i_rd_req) begin
                    addr_d  = i_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_c) begin
                    rd_valid_d = 1'b1;
                    hit_d      = 1'b1;
                    rd_data_d  = hit_data_c;
                    state_d    = S_IDLE;
                end else begin
                    mem_req_d  = 1'b1;
                    state_d    = S_MISS;
                end
            end
            S_MISS: begin
                if (i_mem_ack) begin
                    fill_d    = i_mem_data;
                    mem_req_d = 1'b0;
                    state_d   = S_REFILL;
                end
            end
            S_REFILL: begin
                rd_valid_d = 1'b1;
                hit_d      = 1'b0;
                rd_data_d  = fill_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        modify_d = (state_d == S_REFILL);
        block_d  = (state_d == S_REFILL);
    end

    assign o_busy     = busy_q;
    assign o_rd_valid = rd_valid_q;
    assign o_hit      = hit_q;
    assign o_rd_data  = rd_data_q;
    assign o_mem_req  = mem_req_q;
    assign o_mem_addr = addr_q;
    assign o_modify   = modify_q;
    assign o_block    = block_q;
    assign o_index    = addr_q[1:0];

endmodule
